// File: rtl/xup_xnor_compare_arbiter.sv
// Round-robin arbiter that lets two requesters share one external xnor vector
// for multi-word equality compares, returning a done pulse with match/err.
module xup_xnor_compare_arbiter #(
  parameter int unsigned SIZE      = 4,
  parameter int unsigned MAX_WORDS = 8
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [1:0]                       req_valid,
  input  logic [2*SIZE-1:0]                req_a,
  input  logic [2*SIZE-1:0]                req_b,
  input  logic [1:0]                       req_last,
  output logic [1:0]                       req_ready,
  output logic [1:0]                       done,
  output logic                             match,
  output logic                             err,
  output logic [$clog2(MAX_WORDS+1)-1:0]   word_cnt,
  output logic [SIZE-1:0]                  xv_a,
  output logic [SIZE-1:0]                  xv_b,
  input  logic [SIZE-1:0]                  xv_y
);

  localparam int unsigned CntW = $clog2(MAX_WORDS + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(MAX_WORDS - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e state;
  logic   gnt;
  logic   rr_ptr;
  logic   acc;

  logic grant_sel;
  logic xfer;
  logic word_match;
  logic cur_last;
  logic finish;

  // Contention goes to rr_ptr; otherwise the single valid requester wins.
  assign grant_sel  = (&req_valid) ? rr_ptr : req_valid[1];
  assign xfer       = req_valid[gnt] & req_ready[gnt];
  assign word_match = &xv_y;
  assign cur_last   = req_last[gnt];
  assign finish     = cur_last | (word_cnt == LastCnt);

  always_comb begin
    xv_a = '0;
    xv_b = '0;
    if (state == StBusy) begin
      xv_a = gnt ? req_a[2*SIZE-1:SIZE] : req_a[SIZE-1:0];
      xv_b = gnt ? req_b[2*SIZE-1:SIZE] : req_b[SIZE-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= StIdle;
      gnt       <= 1'b0;
      rr_ptr    <= 1'b0;
      acc       <= 1'b1;
      word_cnt  <= '0;
      req_ready <= 2'b00;
      done      <= 2'b00;
      match     <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 2'b00;
      unique case (state)
        StIdle: begin
          if (|req_valid) begin
            gnt       <= grant_sel;
            req_ready <= grant_sel ? 2'b10 : 2'b01;
            acc       <= 1'b1;
            word_cnt  <= '0;
            state     <= StBusy;
          end
        end
        StBusy: begin
          if (xfer) begin
            acc      <= acc & word_match;
            word_cnt <= word_cnt + 1'b1;
            if (finish) begin
              // A last on the final allowed word is a normal completion.
              req_ready <= 2'b00;
              done      <= gnt ? 2'b10 : 2'b01;
              match     <= acc & word_match & cur_last;
              err       <= ~cur_last;
              state     <= StDone;
            end
          end
        end
        StDone: begin
          rr_ptr <= ~gnt;
          state  <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
